// File: rtl/clock_pkg.sv
// Shared BCD types, terminal values and digit helpers for the
// time-of-day counter.
package clock_pkg;

    typedef logic [7:0] bcd8_t;

    typedef struct packed {
        logic  wrap;
        bcd8_t val;
    } bcd_inc_t;

    localparam bcd8_t BCD_SEC_MAX  = 8'h59;
    localparam bcd8_t BCD_MIN_MAX  = 8'h59;
    localparam bcd8_t BCD_HOUR_MAX = 8'h23;

    localparam int PRE_W = 10;

    // Two-digit BCD increment that wraps to 00 at the terminal value.
    function automatic bcd_inc_t bcd_inc(input bcd8_t v, input bcd8_t max);
        bcd_inc_t r;
        r.wrap = 1'b0;
        r.val  = 8'h00;
        if (v >= max) begin
            r.wrap = 1'b1;
            r.val  = 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            r.val = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r.val = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic bcd_legal(input bcd8_t v, input bcd8_t max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with load priority over increment;
// wrap flags an increment taken at the terminal value.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd8_t MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       wrap
);

    bcd8_t    value_q;
    bcd8_t    value_d;
    bcd_inc_t nxt;

    always_comb begin
        nxt     = bcd_inc(value_q, MAX);
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (inc) begin
            value_d = nxt.val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= 8'h00;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign wrap  = inc & ~load & nxt.wrap;

endmodule

// File: rtl/time_counter.sv
// BCD hh:mm:ss counter with preset, adjust, prescaled tick and carries.
// Optional hourly chime built when HOURLY_CHIME_EN is defined.
module time_counter
    import clock_pkg::*;
#(
    parameter int    TICK_DIV = 1,
    parameter bcd8_t SEC_MAX  = 8'h59
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       tick_in,
    input  logic       run_en,
    input  logic       PE,
    input  logic [7:0] pre_hour,
    input  logic [7:0] pre_min,
    input  logic       adj_min,
    input  logic       adj_hour,
    output logic [7:0] show_hour,
    output logic [7:0] show_min,
    output logic [7:0] show_sec,
    output logic       sec_carry,
    output logic       min_carry,
    output logic       day_carry,
    output logic       pre_err,
    output logic       chime
);

    localparam logic [PRE_W-1:0] DIV_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] div_q;
    logic [PRE_W-1:0] div_d;

    logic qtick;
    logic adj_any;
    logic pre_ok;
    logic pre_load;
    logic adv;

    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;
    logic min_inc;
    logic hour_inc;

    logic sec_carry_q, sec_carry_d;
    logic min_carry_q, min_carry_d;
    logic day_carry_q, day_carry_d;
    logic pre_err_q,   pre_err_d;

    assign qtick    = tick_in & run_en;
    assign adj_any  = adj_min | adj_hour;
    assign pre_ok   = bcd_legal(pre_hour, BCD_HOUR_MAX)
                    & bcd_legal(pre_min, BCD_MIN_MAX);
    assign pre_load = PE & pre_ok;

    // A lower-priority event is dropped, never queued.
    assign adv = ~PE & ~adj_any & qtick & (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (PE || adj_any) begin
            div_d = '0;
        end else if (qtick) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    assign min_inc  = (adv & sec_wrap) | (~PE & adj_min);
    assign hour_inc = (adv & sec_wrap & min_wrap) | (~PE & adj_hour);

    always_comb begin
        sec_carry_d = adv & sec_wrap;
        min_carry_d = adv & sec_wrap & min_wrap;
        day_carry_d = adv & sec_wrap & min_wrap & hour_wrap;
        pre_err_d   = PE & ~pre_ok;
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            div_q       <= '0;
            sec_carry_q <= 1'b0;
            min_carry_q <= 1'b0;
            day_carry_q <= 1'b0;
            pre_err_q   <= 1'b0;
        end else begin
            div_q       <= div_d;
            sec_carry_q <= sec_carry_d;
            min_carry_q <= min_carry_d;
            day_carry_q <= day_carry_d;
            pre_err_q   <= pre_err_d;
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk      (CP),
        .rst      (CR),
        .inc      (adv),
        .load     (pre_load),
        .load_val (8'h00),
        .value    (show_sec),
        .wrap     (sec_wrap)
    );

    bcd_mod_counter #(.MAX(BCD_MIN_MAX)) u_min (
        .clk      (CP),
        .rst      (CR),
        .inc      (min_inc),
        .load     (pre_load),
        .load_val (pre_min),
        .value    (show_min),
        .wrap     (min_wrap)
    );

    bcd_mod_counter #(.MAX(BCD_HOUR_MAX)) u_hour (
        .clk      (CP),
        .rst      (CR),
        .inc      (hour_inc),
        .load     (pre_load),
        .load_val (pre_hour),
        .value    (show_hour),
        .wrap     (hour_wrap)
    );

    assign sec_carry = sec_carry_q;
    assign min_carry = min_carry_q;
    assign day_carry = day_carry_q;
    assign pre_err   = pre_err_q;

`ifdef HOURLY_CHIME_EN
    logic chime_q;
    logic chime_d;

    // Starts on the tick into xx:00:00, ends on the tick into xx:00:05.
    always_comb begin
        chime_d = chime_q;
        if (PE || adj_any) begin
            chime_d = 1'b0;
        end else if (adv && sec_wrap && min_wrap) begin
            chime_d = 1'b1;
        end else if (adv && show_sec == 8'h04) begin
            chime_d = 1'b0;
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            chime_q <= 1'b0;
        end else begin
            chime_q <= chime_d;
        end
    end

    assign chime = chime_q;
`else
    assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: reset, preset, carries, adjust,
// prescaler division and the optional hourly chime.
module tb_time_counter;

    logic       CP = 1'b0;
    logic       CR;
    logic       tick_in;
    logic       run_en;
    logic       PE;
    logic [7:0] pre_hour;
    logic [7:0] pre_min;
    logic       adj_min;
    logic       adj_hour;

    logic [7:0] show_hour, show_min, show_sec;
    logic       sec_carry, min_carry, day_carry, pre_err, chime;

    logic [7:0] d_hour, d_min, d_sec;
    logic       d_sc, d_mc, d_dc, d_pe, d_ch;

    int checks = 0;
    int errors = 0;

`ifdef HOURLY_CHIME_EN
    localparam logic CH = 1'b1;
`else
    localparam logic CH = 1'b0;
`endif

    always #5 CP = ~CP;

    time_counter u_dut (
        .CP        (CP),
        .CR        (CR),
        .tick_in   (tick_in),
        .run_en    (run_en),
        .PE        (PE),
        .pre_hour  (pre_hour),
        .pre_min   (pre_min),
        .adj_min   (adj_min),
        .adj_hour  (adj_hour),
        .show_hour (show_hour),
        .show_min  (show_min),
        .show_sec  (show_sec),
        .sec_carry (sec_carry),
        .min_carry (min_carry),
        .day_carry (day_carry),
        .pre_err   (pre_err),
        .chime     (chime)
    );

    time_counter #(.TICK_DIV(4)) u_div (
        .CP        (CP),
        .CR        (CR),
        .tick_in   (tick_in),
        .run_en    (run_en),
        .PE        (PE),
        .pre_hour  (pre_hour),
        .pre_min   (pre_min),
        .adj_min   (adj_min),
        .adj_hour  (adj_hour),
        .show_hour (d_hour),
        .show_min  (d_min),
        .show_sec  (d_sec),
        .sec_carry (d_sc),
        .min_carry (d_mc),
        .day_carry (d_dc),
        .pre_err   (d_pe),
        .chime     (d_ch)
    );

    task automatic cycle();
        @(posedge CP);
        #1;
    endtask

    task automatic ticks(input int n);
        tick_in = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        tick_in = 1'b0;
    endtask

    task automatic preset(input logic [7:0] h, input logic [7:0] m);
        PE = 1'b1; pre_hour = h; pre_min = m;
        cycle();
        PE = 1'b0;
    endtask

    task automatic test_reset();
        CR = 1'b1;
        cycle(); cycle();
        CR = 1'b0;
        checks++;
        if ({show_hour, show_min, show_sec} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_time got %h want 000000",
                     {show_hour, show_min, show_sec});
        end
        checks++;
        if ({sec_carry, min_carry, day_carry, pre_err, chime} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b want 00000",
                     {sec_carry, min_carry, day_carry, pre_err, chime});
        end
        ticks(1);
        checks++;
        if ({show_hour, show_min, show_sec} !== 24'h000001) begin
            errors++;
            $display("FAIL first_tick got %h want 000001",
                     {show_hour, show_min, show_sec});
        end
    endtask

    task automatic test_preset();
        preset(8'h12, 8'h31);
        checks++;
        if ({show_hour, show_min, show_sec, pre_err} !== {24'h123100, 1'b0}) begin
            errors++;
            $display("FAIL preset_load got %h err %b want 123100 err 0",
                     {show_hour, show_min, show_sec}, pre_err);
        end
        ticks(59);
        checks++;
        if ({show_hour, show_min, show_sec, sec_carry} !== {24'h123159, 1'b0}) begin
            errors++;
            $display("FAIL count_59 got %h sc %b want 123159 sc 0",
                     {show_hour, show_min, show_sec}, sec_carry);
        end
        ticks(1);
        checks++;
        if ({show_hour, show_min, show_sec, sec_carry, min_carry}
            !== {24'h123200, 2'b10}) begin
            errors++;
            $display("FAIL sec_wrap got %h sc %b mc %b want 123200 sc 1 mc 0",
                     {show_hour, show_min, show_sec}, sec_carry, min_carry);
        end
        cycle();
        checks++;
        if ({show_hour, show_min, show_sec, sec_carry} !== {24'h123200, 1'b0}) begin
            errors++;
            $display("FAIL sc_one_cycle got %h sc %b want 123200 sc 0",
                     {show_hour, show_min, show_sec}, sec_carry);
        end
    endtask

    task automatic test_day_wrap();
        preset(8'h23, 8'h59);
        ticks(59);
        ticks(1);
        checks++;
        if ({show_hour, show_min, show_sec, sec_carry, min_carry, day_carry}
            !== {24'h000000, 3'b111}) begin
            errors++;
            $display("FAIL day_wrap got %h carries %b want 000000 carries 111",
                     {show_hour, show_min, show_sec},
                     {sec_carry, min_carry, day_carry});
        end
        checks++;
        if (chime !== CH) begin
            errors++;
            $display("FAIL day_chime got %b want %b", chime, CH);
        end
        cycle();
        checks++;
        if ({sec_carry, min_carry, day_carry} !== 3'b000) begin
            errors++;
            $display("FAIL carry_drop got %b want 000",
                     {sec_carry, min_carry, day_carry});
        end
    endtask

    task automatic test_pre_err();
        preset(8'h09, 8'h00);
        checks++;
        if ({show_hour, show_min, show_sec, pre_err, chime}
            !== {24'h090000, 2'b00}) begin
            errors++;
            $display("FAIL load_0900 got %h err %b ch %b want 090000 0 0",
                     {show_hour, show_min, show_sec}, pre_err, chime);
        end
        preset(8'h24, 8'h00);
        checks++;
        if ({show_hour, show_min, show_sec, pre_err} !== {24'h090000, 1'b1}) begin
            errors++;
            $display("FAIL bad_hour got %h err %b want 090000 err 1",
                     {show_hour, show_min, show_sec}, pre_err);
        end
        preset(8'h12, 8'h5A);
        checks++;
        if ({show_hour, show_min, show_sec, pre_err} !== {24'h090000, 1'b1}) begin
            errors++;
            $display("FAIL bad_min got %h err %b want 090000 err 1",
                     {show_hour, show_min, show_sec}, pre_err);
        end
        PE = 1'b1; pre_hour = 8'h07; pre_min = 8'h45; tick_in = 1'b1;
        cycle(); cycle(); cycle();
        PE = 1'b0; tick_in = 1'b0;
        checks++;
        if ({show_hour, show_min, show_sec, pre_err} !== {24'h074500, 1'b0}) begin
            errors++;
            $display("FAIL pe_freeze got %h err %b want 074500 err 0",
                     {show_hour, show_min, show_sec}, pre_err);
        end
        cycle();
        checks++;
        if (pre_err !== 1'b0) begin
            errors++;
            $display("FAIL err_drop got %b want 0", pre_err);
        end
    endtask

    task automatic test_adjust();
        preset(8'h10, 8'h59);
        ticks(30);
        adj_min = 1'b1; tick_in = 1'b1;
        cycle();
        adj_min = 1'b0; tick_in = 1'b0;
        checks++;
        if ({show_hour, show_min, show_sec, sec_carry, min_carry}
            !== {24'h100030, 2'b00}) begin
            errors++;
            $display("FAIL adj_min got %h carries %b want 100030 00",
                     {show_hour, show_min, show_sec}, {sec_carry, min_carry});
        end
        preset(8'h23, 8'h15);
        adj_hour = 1'b1;
        cycle();
        adj_hour = 1'b0;
        checks++;
        if ({show_hour, show_min, show_sec} !== 24'h001500) begin
            errors++;
            $display("FAIL adj_hour got %h want 001500",
                     {show_hour, show_min, show_sec});
        end
        preset(8'h19, 8'h59);
        adj_min = 1'b1; adj_hour = 1'b1;
        cycle();
        adj_min = 1'b0; adj_hour = 1'b0;
        checks++;
        if ({show_hour, show_min, show_sec, day_carry} !== {24'h200000, 1'b0}) begin
            errors++;
            $display("FAIL adj_both got %h dc %b want 200000 dc 0",
                     {show_hour, show_min, show_sec}, day_carry);
        end
    endtask

    task automatic test_div();
        CR = 1'b1;
        cycle();
        CR = 1'b0;
        ticks(3);
        checks++;
        if ({d_hour, d_min, d_sec} !== 24'h000000) begin
            errors++;
            $display("FAIL div_3 got %h want 000000", {d_hour, d_min, d_sec});
        end
        ticks(1);
        checks++;
        if ({d_hour, d_min, d_sec} !== 24'h000001) begin
            errors++;
            $display("FAIL div_4 got %h want 000001", {d_hour, d_min, d_sec});
        end
        run_en = 1'b0;
        ticks(5);
        run_en = 1'b1;
        ticks(2);
        run_en = 1'b0;
        ticks(3);
        run_en = 1'b1;
        ticks(1);
        checks++;
        if ({d_hour, d_min, d_sec} !== 24'h000001) begin
            errors++;
            $display("FAIL div_hold got %h want 000001", {d_hour, d_min, d_sec});
        end
        ticks(1);
        checks++;
        if ({d_hour, d_min, d_sec} !== 24'h000002) begin
            errors++;
            $display("FAIL div_resume got %h want 000002", {d_hour, d_min, d_sec});
        end
        ticks(2);
        adj_min = 1'b1;
        cycle();
        adj_min = 1'b0;
        ticks(3);
        checks++;
        if ({d_hour, d_min, d_sec} !== 24'h000102) begin
            errors++;
            $display("FAIL div_adjclr got %h want 000102", {d_hour, d_min, d_sec});
        end
        ticks(1);
        checks++;
        if ({d_hour, d_min, d_sec} !== 24'h000103) begin
            errors++;
            $display("FAIL div_after_adj got %h want 000103", {d_hour, d_min, d_sec});
        end
    endtask

    task automatic test_chime();
        preset(8'h12, 8'h59);
        ticks(59);
        checks++;
        if (chime !== 1'b0) begin
            errors++;
            $display("FAIL chime_pre got %b want 0", chime);
        end
        ticks(1);
        checks++;
        if ({show_hour, show_min, show_sec, chime} !== {24'h130000, CH}) begin
            errors++;
            $display("FAIL chime_start got %h ch %b want 130000 ch %b",
                     {show_hour, show_min, show_sec}, chime, CH);
        end
        ticks(4);
        checks++;
        if ({show_sec, chime} !== {8'h04, CH}) begin
            errors++;
            $display("FAIL chime_hold got %h ch %b want 04 ch %b",
                     show_sec, chime, CH);
        end
        ticks(1);
        checks++;
        if ({show_sec, chime} !== {8'h05, 1'b0}) begin
            errors++;
            $display("FAIL chime_end got %h ch %b want 05 ch 0",
                     show_sec, chime);
        end
        preset(8'h13, 8'h59);
        ticks(60);
        adj_min = 1'b1;
        cycle();
        adj_min = 1'b0;
        checks++;
        if ({show_hour, show_min, show_sec, chime} !== {24'h140100, 1'b0}) begin
            errors++;
            $display("FAIL chime_adjclr got %h ch %b want 140100 ch 0",
                     {show_hour, show_min, show_sec}, chime);
        end
        preset(8'h15, 8'h00);
        checks++;
        if (chime !== 1'b0) begin
            errors++;
            $display("FAIL chime_preset got %b want 0", chime);
        end
    endtask

    initial begin
        CR = 1'b1; tick_in = 1'b0; run_en = 1'b1; PE = 1'b0;
        pre_hour = 8'h00; pre_min = 8'h00;
        adj_min = 1'b0; adj_hour = 1'b0;
        test_reset();
        test_preset();
        test_day_wrap();
        test_pre_err();
        test_adjust();
        test_div();
        test_chime();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
